// File: rtl/priority_decoder_4to9.sv
// Registered 4-to-9 decoder with valid/ready handshake and a timed one-hot hold.
// Optional feature macro: CODE_ERR_EN (flag codes 10..15 with a one-cycle code_err pulse).
module priority_decoder_4to9 #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       code_valid,
  input  logic [3:0] code,
  output logic       code_ready,
  output logic [8:0] out,
  output logic       busy,
  output logic [3:0] last_code,
  output logic       code_err
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_LOAD = CNT_W'(HOLD_CYCLES - 1);

  state_t           r_state;
  logic             r_ready;
  logic [8:0]       r_out;
  logic [3:0]       r_last;
  logic [CNT_W-1:0] r_cnt;

  logic [8:0]       w_onehot;
  logic             w_legal;
  logic             w_accept;

  // Codes 1..9 select a single line; 0 and 10..15 leave w_onehot empty.
  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < 9; i++) begin
      if (code == 4'(i + 1)) w_onehot[i] = 1'b1;
    end
    w_legal = |w_onehot;
  end

  assign w_accept = code_valid && r_ready;

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_ready <= 1'b1;
      r_out   <= '0;
      r_last  <= '0;
      r_cnt   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_legal) begin
              r_out   <= w_onehot;
              r_last  <= code;
              r_cnt   <= HOLD_LOAD;
              r_ready <= 1'b0;
              r_state <= S_HOLD;
            end else begin
`ifdef CODE_ERR_EN
              // Illegal codes leave last_code untouched; only code 0 clears it.
              if (code == 4'd0) r_last <= '0;
`else
              r_last <= '0;
`endif
            end
          end
        end
        S_HOLD: begin
          if (r_cnt == '0) begin
            r_out   <= '0;
            r_ready <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: begin
          r_out   <= '0;
          r_ready <= 1'b1;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

`ifdef CODE_ERR_EN
  logic r_err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err <= 1'b0;
    end else begin
      r_err <= w_accept && (code > 4'd9);
    end
  end

  assign code_err = r_err;
`else
  assign code_err = 1'b0;
`endif

  assign code_ready = r_ready;
  assign busy       = (r_state == S_HOLD);
  assign out        = r_out;
  assign last_code  = r_last;

endmodule

// File: tb/tb_priority_decoder_4to9.sv
// Directed self-checking bench for priority_decoder_4to9 (HOLD_CYCLES=4 and HOLD_CYCLES=1 instances).
module tb_priority_decoder_4to9;

  logic       clk;
  logic       rst_n;
  logic       code_valid;
  logic [3:0] code;
  logic       code_ready;
  logic [8:0] out;
  logic       busy;
  logic [3:0] last_code;
  logic       code_err;

  logic       valid1;
  logic [3:0] code1;
  logic       ready1;
  logic [8:0] out1;
  logic       busy1;
  logic [3:0] last1;
  logic       err1;

  int n_tests;
  int n_fail;

  priority_decoder_4to9 #(.HOLD_CYCLES(4), .CNT_W(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .code_valid(code_valid), .code(code),
    .code_ready(code_ready), .out(out), .busy(busy),
    .last_code(last_code), .code_err(code_err)
  );

  priority_decoder_4to9 #(.HOLD_CYCLES(1), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .code_valid(valid1), .code(code1),
    .code_ready(ready1), .out(out1), .busy(busy1),
    .last_code(last1), .code_err(err1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference 9-to-4 priority encoder: highest set bit wins (ascending scan, last hit kept).
  function automatic logic [3:0] enc9to4(input logic [8:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < 9; i++) if (v[i]) c = 4'(i + 1);
    return c;
  endfunction

  // Expected one-hot from the raw vector, found by a descending scan.
  function automatic logic [8:0] top_bit(input logic [8:0] v);
    for (int i = 8; i >= 0; i--) if (v[i]) return 9'(1) << i;
    return 9'd0;
  endfunction

  task automatic check_idle(input string name, input logic [3:0] exp_last);
    n_tests++;
    if (out !== 9'd0 || code_ready !== 1'b1 || busy !== 1'b0 || last_code !== exp_last
        || code_err !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: out=%h ready=%b busy=%b last=%0d err=%b, want out=0 ready=1 busy=0 last=%0d err=0",
               name, out, code_ready, busy, last_code, code_err, exp_last);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; code_valid = 1'b0; code = 4'd0; valid1 = 1'b0; code1 = 4'd0;
    #23;
    check_idle("reset_values", 4'd0);
    // code_valid high while reset releases must not transfer before an edge
    code_valid = 1'b1; code = 4'd2;
    #3 rst_n = 1'b1;
    #1;
    check_idle("release_no_transfer", 4'd0);
    step();
    code_valid = 1'b0;
    n_tests++;
    if (out !== 9'h002 || last_code !== 4'd2) begin
      n_fail++;
      $display("FAIL first_accept: out=%h last=%0d, want out=002 last=2", out, last_code);
    end
    repeat (4) step();
    check_idle("first_accept_done", 4'd2);
  endtask

  task automatic test_single();
    code_valid = 1'b1; code = 4'd9;
    step();
    code_valid = 1'b0; code = 4'd0;
    for (int k = 1; k <= 4; k++) begin
      n_tests++;
      if (out !== 9'h100 || code_ready !== 1'b0 || busy !== 1'b1 || last_code !== 4'd9) begin
        n_fail++;
        $display("FAIL single_hold_%0d: out=%h ready=%b busy=%b last=%0d, want out=100 ready=0 busy=1 last=9",
                 k, out, code_ready, busy, last_code);
      end
      if (k < 4) step();
    end
    step();
    check_idle("single_release", 4'd9);
  endtask

  task automatic test_back_to_back();
    logic [8:0] exp;
    code_valid = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      exp = 9'(1) << (i - 1);
      code = 4'(i);
      step();
      for (int k = 0; k < 4; k++) begin
        // decoys presented while code_ready is low must not be consumed
        case (k)
          0: code = 4'd0;
          1: code = 4'd12;
          default: code = (i == 9) ? 4'd1 : 4'(i + 1);
        endcase
        n_tests++;
        if (out !== exp || last_code !== 4'(i) || code_ready !== 1'b0) begin
          n_fail++;
          $display("FAIL sweep_code%0d_cyc%0d: out=%h last=%0d ready=%b, want out=%h last=%0d ready=0",
                   i, k, out, last_code, code_ready, exp, i);
        end
        if (k < 3) step();
      end
      step();
      n_tests++;
      if (out !== 9'd0 || code_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL sweep_gap%0d: out=%h ready=%b, want out=0 ready=1", i, out, code_ready);
      end
    end
    code_valid = 1'b0;
  endtask

  task automatic test_code0_illegal();
    logic exp_err;
    logic [3:0] exp_last12;
`ifdef CODE_ERR_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif
    code_valid = 1'b1; code = 4'd0;
    step();
    check_idle("code0", 4'd0);
    code = 4'd12;
    step();
    code_valid = 1'b0;
    n_tests++;
    if (out !== 9'd0 || code_ready !== 1'b1 || code_err !== exp_err || last_code !== 4'd0) begin
      n_fail++;
      $display("FAIL code12_a: out=%h ready=%b err=%b last=%0d, want out=0 ready=1 err=%b last=0",
               out, code_ready, code_err, last_code, exp_err);
    end
    step();
    check_idle("code12_pulse_end", 4'd0);
    code_valid = 1'b1; code = 4'd3;
    step();
    code_valid = 1'b0;
    n_tests++;
    if (out !== 9'h004 || last_code !== 4'd3) begin
      n_fail++;
      $display("FAIL code3: out=%h last=%0d, want out=004 last=3", out, last_code);
    end
    repeat (4) step();
    check_idle("code3_done", 4'd3);
    // illegal code after a legal one separates "unchanged" from "cleared"
    exp_last12 = exp_err ? 4'd3 : 4'd0;
    code_valid = 1'b1; code = 4'd15;
    step();
    code_valid = 1'b0;
    n_tests++;
    if (out !== 9'd0 || code_err !== exp_err || last_code !== exp_last12 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL code15_b: out=%h err=%b last=%0d busy=%b, want out=0 err=%b last=%0d busy=0",
               out, code_err, last_code, busy, exp_err, exp_last12);
    end
    step();
    check_idle("code15_pulse_end", exp_last12);
  endtask

  task automatic test_reset_mid_hold();
    code_valid = 1'b1; code = 4'd5;
    step();
    code_valid = 1'b0;
    n_tests++;
    if (out !== 9'h010) begin
      n_fail++;
      $display("FAIL midhold_accept: out=%h, want 010", out);
    end
    repeat (2) step();
    #2 rst_n = 1'b0;
    #1;
    check_idle("midhold_async_reset", 4'd0);
    code_valid = 1'b1; code = 4'd7;
    rst_n = 1'b1;
    step();
    code_valid = 1'b0;
    n_tests++;
    if (out !== 9'h040 || last_code !== 4'd7 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL midhold_code7: out=%h last=%0d busy=%b, want out=040 last=7 busy=1",
               out, last_code, busy);
    end
    repeat (4) step();
    check_idle("midhold_code7_done", 4'd7);
  endtask

  task automatic test_hold1_round_trip();
    logic [8:0] vec;
    logic [8:0] exp;
    valid1 = 1'b1;
    for (int n = 0; n < 10; n++) begin
      vec = 9'($urandom_range(1, 511));
      exp = top_bit(vec);
      code1 = enc9to4(vec);
      step();
      n_tests++;
      if (out1 !== exp || busy1 !== 1'b1 || ready1 !== 1'b0) begin
        n_fail++;
        $display("FAIL rt_pulse%0d: vec=%h out=%h busy=%b ready=%b, want out=%h busy=1 ready=0",
                 n, vec, out1, busy1, ready1, exp);
      end
      step();
      n_tests++;
      if (out1 !== 9'd0 || ready1 !== 1'b1) begin
        n_fail++;
        $display("FAIL rt_gap%0d: out=%h ready=%b, want out=0 ready=1", n, out1, ready1);
      end
    end
    valid1 = 1'b0;
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_single();
    test_back_to_back();
    test_code0_illegal();
    test_reset_mid_hold();
    test_hold1_round_trip();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
